pixel_brightness_booster: RTL and testbench
===========================================

PIXEL_BRIGHTNESS_BOOSTER -- requirements
Module: pixel_brightness_booster

Interface
REQ-001 Parameter MAX_LEVEL, default 3, meaning highest gain level (left-shift amount), legal range 1..3.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rstN  input  1  reset, synchronous, active-low.
REQ-004 pixelIn  input  12  RGB444 pixel, R=[11:8], G=[7:4], B=[3:0].
REQ-005 pixelInValid  input  1  pixelIn qualifier.
REQ-006 frameStart  input  1  one-cycle pulse at the first pixel cycle of a frame.
REQ-007 levelUp  input  1  debounced, clk-synchronous button level; each rising edge requests gain+1.
REQ-008 levelDown  input  1  debounced, clk-synchronous button level; each rising edge requests gain-1.
REQ-009 pixelOut  output  12  boosted RGB444 pixel.
REQ-010 pixelOutValid  output  1  pixelOut qualifier.
REQ-011 frameStartOut  output  1  frameStart delayed to align with pixelOut.
REQ-012 gainLevel  output  2  gain currently applied to output pixels.
REQ-013 levelPending  output  1  high while a requested gain is waiting for the next frame boundary.

Function
REQ-014 Edge detect: register levelUp/levelDown once; an edge is current=1 and previous=0; holding a button high yields exactly one request.
REQ-015 pendingLevel (2 bits): up edge increments, saturating at MAX_LEVEL; down edge decrements, saturating at 0; simultaneous up and down edges leave it unchanged.
REQ-016 activeLevel loads pendingLevel only in a cycle with frameStart=1; the pixel presented in that same cycle uses the newly loaded level.
REQ-017 Edge and frameStart in the same cycle: frameStart loads the pre-edge pendingLevel; the edge updates pendingLevel for the following frame.
REQ-018 Update FSM, two states: SYNCED (pending==active) and PENDING (pending!=active); SYNCED->PENDING on an edge changing pendingLevel; PENDING->SYNCED on frameStart, or when a later edge returns pendingLevel to activeLevel; levelPending=1 exactly in PENDING.
REQ-019 Pipeline stage 1 registers pixelIn, pixelInValid, frameStart and the level chosen per REQ-016; stage 2 registers the boosted result.
REQ-020 Latency exactly 2 cycles from input to pixelOut/pixelOutValid/frameStartOut; throughput one pixel per cycle; no back-pressure.
REQ-021 Per channel, 4-bit value v at level L: output = v<<L truncated to 4 bits when no 1 bits are shifted out, else 4'hF (saturation); level 0 is pass-through.
REQ-022 Invalid input cycles propagate pixelOutValid=0; pixelOut is then don't-care but shall still be computed (no gating logic required).
REQ-023 gainLevel reflects the stage-2 level, i.e. the gain of the pixel currently on pixelOut.

Reset
REQ-024 While rstN=0 at a clk edge: pixelOut=12'h000, pixelOutValid=0, frameStartOut=0, gainLevel=0, levelPending=0, pendingLevel=activeLevel=0, FSM=SYNCED, edge-detect registers=0.
REQ-025 Reset mid-stream discards both pipeline stages; first valid output after release appears 2 cycles after the first valid input.
REQ-026 A button already held high at reset release shall not generate a request (previous-value registers load current inputs after reset release only via normal sampling; first edge requires a 0 sample).

Structure
REQ-027 Shared package holds the RGB444 channel width (4), the pixel width (12) and the 2-bit level type, reused by the existing darkening shifter.
REQ-028 One sub-module: channel_sat_shift (4-bit value, 2-bit level -> 4-bit saturated result), instantiated three times.

Verification
REQ-029 Level 0, pixelIn=12'hABC valid -> pixelOut=12'hABC, pixelOutValid=1 exactly 2 cycles later.
REQ-030 One levelUp edge, then frameStart with pixelIn=12'h357 -> pixelOut=12'h6AE, gainLevel=1; second edge and frame -> 12'h357 gives 12'hCFF.
REQ-031 levelUp held high 5 cycles -> pendingLevel +1 only; 4 edges from 0 with MAX_LEVEL=3 -> pendingLevel=3.
REQ-032 levelUp edge mid-frame -> levelPending=1, output gain unchanged until next frameStart, then levelPending=0.
REQ-033 Simultaneous up and down edges -> no change, levelPending stays 0.
REQ-034 rstN=0 for one cycle during valid stream at level 2 -> next cycle all outputs zero, gainLevel=0, stream resumes at level 0.

Source files
------------

// File: rtl/pixel_brightness_booster_pkg.sv
// Shared RGB444 types for the brightness booster and darkening shifter.
// Holds channel/pixel widths, level type and stage bundle.
package pixel_brightness_booster_pkg;

  localparam int CH_W  = 4;
  localparam int PIX_W = 3 * CH_W;

  typedef logic [1:0]       level_t;
  typedef logic [CH_W-1:0]  chan_t;
  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic {
    SYNCED,
    PENDING
  } upd_state_t;

  typedef struct packed {
    pix_t   pix;
    logic   vld;
    logic   fs;
    level_t lvl;
  } stage_t;

endpackage

// File: rtl/pixel_brightness_booster_if.sv
// Pixel stream and gain-control bundle for the brightness booster.
// master drives pixels/buttons, slave is the booster.
interface pixel_brightness_booster_if;
  import pixel_brightness_booster_pkg::*;

  pix_t   pixelIn;
  logic   pixelInValid;
  logic   frameStart;
  logic   levelUp;
  logic   levelDown;
  pix_t   pixelOut;
  logic   pixelOutValid;
  logic   frameStartOut;
  level_t gainLevel;
  logic   levelPending;

  modport master (
    output pixelIn, pixelInValid, frameStart,
    output levelUp, levelDown,
    input  pixelOut, pixelOutValid, frameStartOut,
    input  gainLevel, levelPending
  );

  modport slave (
    input  pixelIn, pixelInValid, frameStart,
    input  levelUp, levelDown,
    output pixelOut, pixelOutValid, frameStartOut,
    output gainLevel, levelPending
  );

endinterface

// File: rtl/pixel_brightness_booster_channel_sat_shift.sv
// One colour channel left-shifted by the gain level.
// Any bit shifted out saturates the channel to full scale.
module channel_sat_shift
  import pixel_brightness_booster_pkg::*;
(
  input  chan_t  val_i,
  input  level_t lvl_i,
  output chan_t  res_o
);

  logic [CH_W+2:0] wide;

  assign wide  = {3'b000, val_i} << lvl_i;
  assign res_o = (|wide[CH_W+2:CH_W]) ? '1 : wide[CH_W-1:0];

endmodule

// File: rtl/pixel_brightness_booster.sv
// Two-stage RGB444 brightness booster with button-driven gain
// that only takes effect on frame boundaries.
module pixel_brightness_booster
  import pixel_brightness_booster_pkg::*;
#(
  parameter int MAX_LEVEL = 3
) (
  input logic clk,
  input logic rstN,
  pixel_brightness_booster_if.slave px
);

  localparam level_t MAX_L = level_t'(MAX_LEVEL);

  logic       upPrev_q, dnPrev_q;
  logic       upArm_q, dnArm_q;
  logic       upEdge, dnEdge;
  level_t     pend_q, pend_d;
  level_t     act_q, act_d;
  upd_state_t state_q, state_d;
  stage_t     s1_q, s1_d;
  stage_t     s2_q, s2_d;
  pix_t       boost;

  // Arm flags keep a button held through reset from counting as a press
  assign upEdge = px.levelUp & ~upPrev_q & upArm_q;
  assign dnEdge = px.levelDown & ~dnPrev_q & dnArm_q;

  always_comb begin
    pend_d = pend_q;
    unique case ({upEdge, dnEdge})
      2'b10: if (pend_q != MAX_L) pend_d = pend_q + 2'd1;
      2'b01: if (pend_q != 2'd0) pend_d = pend_q - 2'd1;
      default: ;
    endcase
  end

  assign act_d = px.frameStart ? pend_q : act_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNCED:  if (pend_d != act_d) state_d = PENDING;
      PENDING: if (pend_d == act_d) state_d = SYNCED;
      default: state_d = SYNCED;
    endcase
  end

  always_comb begin
    s1_d     = '0;
    s1_d.pix = px.pixelIn;
    s1_d.vld = px.pixelInValid;
    s1_d.fs  = px.frameStart;
    s1_d.lvl = act_d;
  end

  for (genvar c = 0; c < 3; c++) begin : g_ch
    channel_sat_shift u_sh (
      .val_i (s1_q.pix[c*CH_W +: CH_W]),
      .lvl_i (s1_q.lvl),
      .res_o (boost[c*CH_W +: CH_W])
    );
  end

  always_comb begin
    s2_d     = s1_q;
    s2_d.pix = boost;
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      upPrev_q <= 1'b0;
      dnPrev_q <= 1'b0;
      upArm_q  <= 1'b0;
      dnArm_q  <= 1'b0;
      pend_q   <= '0;
      act_q    <= '0;
      state_q  <= SYNCED;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      upPrev_q <= px.levelUp;
      dnPrev_q <= px.levelDown;
      upArm_q  <= upArm_q | ~px.levelUp;
      dnArm_q  <= dnArm_q | ~px.levelDown;
      pend_q   <= pend_d;
      act_q    <= act_d;
      state_q  <= state_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
    end
  end

  assign px.pixelOut      = s2_q.pix;
  assign px.pixelOutValid = s2_q.vld;
  assign px.frameStartOut = s2_q.fs;
  assign px.gainLevel     = s2_q.lvl;
  assign px.levelPending  = (state_q == PENDING);

endmodule

// File: tb/tb_pixel_brightness_booster.sv
// Randomized and directed bench for the brightness booster,
// checked against a frame-level arithmetic model.
module tb_pixel_brightness_booster;
  import pixel_brightness_booster_pkg::*;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  pixel_brightness_booster_if px();

  pixel_brightness_booster #(.MAX_LEVEL(3)) dut (
    .clk  (clk),
    .rstN (rstN),
    .px   (px)
  );

  int checks = 0;
  int failures = 0;

  int mPend, mAct;
  bit mUpPrev, mDnPrev, mUpSeen, mDnSeen;
  int e1Pix, e1Lvl, e2Pix, e2Lvl;
  bit e1V, e1F, e2V, e2F;

  function automatic int boost(int p, int l);
    int r, o;
    o = 0;
    for (int c = 0; c < 3; c++) begin
      r = ((p >> (4 * c)) & 15) * (1 << l);
      if (r > 15) r = 15;
      o = o | (r << (4 * c));
    end
    return o;
  endfunction

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(bit r, int p, bit v, bit f, bit u, bit d);
    bit upE, dnE;
    rstN            = r;
    px.pixelIn      = p[11:0];
    px.pixelInValid = v;
    px.frameStart   = f;
    px.levelUp      = u;
    px.levelDown    = d;
    @(posedge clk);
    #1;
    if (!r) begin
      mPend = 0; mAct = 0;
      mUpPrev = 0; mDnPrev = 0; mUpSeen = 0; mDnSeen = 0;
      e1Pix = 0; e1Lvl = 0; e1V = 0; e1F = 0;
      e2Pix = 0; e2Lvl = 0; e2V = 0; e2F = 0;
    end else begin
      e2Pix = boost(e1Pix, e1Lvl);
      e2Lvl = e1Lvl; e2V = e1V; e2F = e1F;
      e1Pix = p & 'hFFF;
      e1Lvl = f ? mPend : mAct;
      e1V = v; e1F = f;
      upE = u && !mUpPrev && mUpSeen;
      dnE = d && !mDnPrev && mDnSeen;
      if (f) mAct = mPend;
      if (upE && !dnE && mPend < 3) mPend++;
      else if (dnE && !upE && mPend > 0) mPend--;
      mUpSeen = mUpSeen || !u;
      mDnSeen = mDnSeen || !d;
      mUpPrev = u;
      mDnPrev = d;
    end
    chk("pixelOut", int'(px.pixelOut), e2Pix);
    chk("pixelOutValid", int'(px.pixelOutValid), int'(e2V));
    chk("frameStartOut", int'(px.frameStartOut), int'(e2F));
    chk("gainLevel", int'(px.gainLevel), e2Lvl);
    chk("levelPending", int'(px.levelPending), int'(mPend != mAct));
  endtask

  task automatic idle();
    cycle(1, 0, 0, 0, 0, 0);
  endtask

  bit ru, rd;

  initial begin
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("rst_pix", int'(px.pixelOut), 0);
    chk("rst_gain", int'(px.gainLevel), 0);
    idle();
    idle();

    cycle(1, 'hABC, 1, 0, 0, 0);
    idle();
    chk("pass_pix", int'(px.pixelOut), 'hABC);
    chk("pass_vld", int'(px.pixelOutValid), 1);

    cycle(1, 0, 0, 0, 1, 0);
    idle();
    chk("mid_pend", int'(px.levelPending), 1);
    chk("mid_gain", int'(px.gainLevel), 0);
    cycle(1, 'h357, 1, 1, 0, 0);
    chk("fs_pend", int'(px.levelPending), 0);
    idle();
    chk("g1_pix", int'(px.pixelOut), 'h6AE);
    chk("g1_gain", int'(px.gainLevel), 1);
    cycle(1, 0, 0, 0, 1, 0);
    idle();
    cycle(1, 'h357, 1, 1, 0, 0);
    idle();
    chk("g2_pix", int'(px.pixelOut), 'hCFF);
    chk("g2_gain", int'(px.gainLevel), 2);

    cycle(1, 0, 0, 0, 1, 1);
    chk("both_pend", int'(px.levelPending), 0);
    idle();

    for (int i = 0; i < 3; i++) cycle(1, 'h123, 1, 0, 0, 0);
    cycle(0, 'h123, 1, 0, 0, 0);
    chk("mrst_pix", int'(px.pixelOut), 0);
    chk("mrst_vld", int'(px.pixelOutValid), 0);
    chk("mrst_gain", int'(px.gainLevel), 0);
    chk("mrst_pend", int'(px.levelPending), 0);
    cycle(1, 'h123, 1, 0, 0, 0);
    cycle(1, 'h456, 1, 0, 0, 0);
    chk("resume_pix", int'(px.pixelOut), 'h123);
    chk("resume_gain", int'(px.gainLevel), 0);

    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 1, 0);
    idle();
    cycle(1, 'h111, 1, 1, 0, 0);
    idle();
    chk("hold_gain", int'(px.gainLevel), 1);
    chk("hold_pix", int'(px.pixelOut), 'h222);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0, 1, 0);
      idle();
    end
    cycle(1, 'h111, 1, 1, 0, 0);
    idle();
    chk("sat_gain", int'(px.gainLevel), 3);
    chk("sat_pix", int'(px.pixelOut), 'h888);

    cycle(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1, 0);
    chk("held_pend", int'(px.levelPending), 0);
    idle();
    cycle(1, 0, 0, 1, 0, 0);
    idle();
    idle();
    chk("held_gain", int'(px.gainLevel), 0);

    ru = 0; rd = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) ru = ~ru;
      if ($urandom_range(0, 3) == 0) rd = ~rd;
      cycle($urandom_range(0, 149) != 0, int'($urandom_range(0, 4095)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, ru, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
